// File: rtl/l4_wave_fifo.sv
// Wavefront coordinate queue: first-word fall-through FIFO with occupancy,
// peak-occupancy tracking and sticky overflow/underflow flags.
module l4_wave_fifo #(
    parameter int NBITS = 10,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             push,
    input  logic [NBITS-1:0] din,
    input  logic             pop,
    output logic [NBITS-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic [AW:0]      hiwat,
    output logic             ovf,
    output logic             udf
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [NBITS-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count_nxt;
    logic             push_ok;
    logic             pop_ok;
    logic             mem_we;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign dout  = mem[rptr];

    // A pop frees a slot on the same edge, so push is accepted even when full.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign mem_we  = push_ok && !clr && resetn;

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok)
            count_nxt = count + 1'b1;
        else if (pop_ok && !push_ok)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            hiwat <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            hiwat <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop_ok)
                rptr <= rptr + 1'b1;
            count <= count_nxt;
            if (count_nxt > hiwat)
                hiwat <= count_nxt;
            if (push && !push_ok)
                ovf <= 1'b1;
            if (pop && empty)
                udf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_l4_wave_fifo.sv
// Scoreboard bench for l4_wave_fifo: stimulus queues expected words, a
// negedge monitor checks dout on every accepted pop.
module tb_l4_wave_fifo;

    logic       clk = 1'b0;
    logic       resetn;
    logic       clr;
    logic       push;
    logic [9:0] din;
    logic       pop;
    logic [9:0] dout;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic [4:0] hiwat;
    logic       ovf;
    logic       udf;

    int tests = 0;
    int fails = 0;
    logic [9:0] exp_q [$];

    l4_wave_fifo #(.NBITS(10), .DEPTH(16), .AW(4)) dut (
        .clk(clk), .resetn(resetn), .clr(clr), .push(push), .din(din),
        .pop(pop), .dout(dout), .empty(empty), .full(full), .count(count),
        .hiwat(hiwat), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc(input logic p, input logic [9:0] d, input logic q, input logic c);
        push = p;
        din  = d;
        pop  = q;
        clr  = c;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic check_flags(input string name, input int cnt, input int hw,
                               input logic o, input logic u);
        check({name, ".count"}, int'(count), cnt);
        check({name, ".hiwat"}, int'(hiwat), hw);
        check({name, ".empty"}, int'(empty), int'(cnt == 0));
        check({name, ".full"}, int'(full), int'(cnt == 16));
        check({name, ".ovf"}, int'(ovf), int'(o));
        check({name, ".udf"}, int'(udf), int'(u));
    endtask

    // Monitor: sampled mid-cycle, the popped word is the one on dout now.
    always @(negedge clk) begin
        if (resetn && !clr && pop && !empty) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got 0x%0h expected no word", dout);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    fails++;
                    $display("FAIL pop_data: got 0x%0h expected 0x%0h", dout, e);
                end
            end
        end
    end

    initial begin
        resetn = 1'b0;
        clr    = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        din    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_flags("reset", 0, 0, 1'b0, 1'b0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // three pushes then three pops
        cyc(1'b1, 10'h001, 1'b0, 1'b0); exp_q.push_back(10'h001);
        check("b1.count1", int'(count), 1);
        check("b1.dout_latency", int'(dout), 'h001);
        check("b1.empty", int'(empty), 0);
        cyc(1'b1, 10'h002, 1'b0, 1'b0); exp_q.push_back(10'h002);
        check("b1.count2", int'(count), 2);
        cyc(1'b1, 10'h003, 1'b0, 1'b0); exp_q.push_back(10'h003);
        check("b1.count3", int'(count), 3);
        cyc(1'b0, 10'h000, 1'b1, 1'b0);
        check("b1.count2b", int'(count), 2);
        cyc(1'b0, 10'h000, 1'b1, 1'b0);
        check("b1.count1b", int'(count), 1);
        cyc(1'b0, 10'h000, 1'b1, 1'b0);
        check_flags("b1.end", 0, 3, 1'b0, 1'b0);

        // fill to full, overflow, push+pop while full, drain
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 10'h100 + 10'(i), 1'b0, 1'b0);
            exp_q.push_back(10'h100 + 10'(i));
        end
        check_flags("full", 16, 16, 1'b0, 1'b0);
        cyc(1'b1, 10'h3FF, 1'b0, 1'b0);
        check_flags("ovf", 16, 16, 1'b1, 1'b0);
        check("ovf.head", int'(dout), 'h100);
        cyc(1'b1, 10'h2AA, 1'b1, 1'b0); exp_q.push_back(10'h2AA);
        check("fullpp.count", int'(count), 16);
        check("fullpp.head", int'(dout), 'h101);
        for (int i = 0; i < 16; i++)
            cyc(1'b0, 10'h000, 1'b1, 1'b0);
        check_flags("drain", 0, 16, 1'b1, 1'b0);

        cyc(1'b0, 10'h000, 1'b0, 1'b1);
        check_flags("clr1", 0, 0, 1'b0, 1'b0);

        // push+pop on empty
        cyc(1'b1, 10'h055, 1'b1, 1'b0); exp_q.push_back(10'h055);
        check_flags("emptypp", 1, 1, 1'b0, 1'b1);
        check("emptypp.dout", int'(dout), 'h055);
        cyc(1'b0, 10'h000, 1'b1, 1'b0);
        cyc(1'b0, 10'h000, 1'b0, 1'b1);
        check_flags("clr2", 0, 0, 1'b0, 1'b0);

        // half-full streaming, pointers wrap several times
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 10'h200 + 10'(i), 1'b0, 1'b0);
            exp_q.push_back(10'h200 + 10'(i));
        end
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 10'h240 + 10'(i), 1'b1, 1'b0);
            exp_q.push_back(10'h240 + 10'(i));
        end
        check_flags("stream", 8, 8, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 10'h000, 1'b1, 1'b0);
        check_flags("stream.drain", 0, 8, 1'b0, 1'b0);

        // clr wins over a simultaneous push
        cyc(1'b1, 10'h077, 1'b0, 1'b0); exp_q.push_back(10'h077);
        cyc(1'b1, 10'h078, 1'b0, 1'b1);
        exp_q.delete();
        check_flags("clr_push", 0, 0, 1'b0, 1'b0);

        // asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 10'h0A0 + 10'(i), 1'b0, 1'b0);
            exp_q.push_back(10'h0A0 + 10'(i));
        end
        cyc(1'b1, 10'h3FF, 1'b1, 1'b0); exp_q.push_back(10'h3FF);
        check("pre_rst.count", int'(count), 5);
        #1 resetn = 1'b0;
        #1;
        exp_q.delete();
        check_flags("async_rst", 0, 0, 1'b0, 1'b0);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 10'h011, 1'b0, 1'b0); exp_q.push_back(10'h011);
        check("rst.push.dout", int'(dout), 'h011);
        check("rst.push.count", int'(count), 1);
        cyc(1'b0, 10'h000, 1'b1, 1'b0);
        check_flags("final", 0, 1, 1'b0, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
